// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Interface : pc_sequencer_if
//  Purpose   : Groups the command handshake, memory read request and program
//              counter control/feedback signals of pc_sequencer.
//  Modports  : master - the sequencer (drives PC controls, memory request,
//                       cmd_ready and done; receives commands, read data and
//                       the PC feedback)
//              slave  - the surrounding system (command source, memory and
//                       program counter)
//  Signals   : cmd_valid/cmd/vec_sel  command and vector select
//              data_in                memory read data / branch offset
//              pcl_in/pch_in          current PC fed back
//              INC_en, PCLin_en, PCHin_en, ADLin_en, ADHin_en, ADLout, ADHout
//                                     program counter controls and load value
//              mem_addr/mem_rd        memory read request
//              cmd_ready/done         handshake status
//  Revision  : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if;
    logic        cmd_valid;
    logic [1:0]  cmd;
    logic [1:0]  vec_sel;
    logic [7:0]  data_in;
    logic [7:0]  pcl_in;
    logic [7:0]  pch_in;

    logic        INC_en;
    logic        PCLin_en;
    logic        PCHin_en;
    logic        ADLin_en;
    logic        ADHin_en;
    logic [7:0]  ADLout;
    logic [7:0]  ADHout;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        cmd_ready;
    logic        done;

    modport master (
        input  cmd_valid, cmd, vec_sel, data_in, pcl_in, pch_in,
        output INC_en, PCLin_en, PCHin_en, ADLin_en, ADHin_en,
        output ADLout, ADHout, mem_addr, mem_rd, cmd_ready, done
    );

    modport slave (
        output cmd_valid, cmd, vec_sel, data_in, pcl_in, pch_in,
        input  INC_en, PCLin_en, PCHin_en, ADLin_en, ADHin_en,
        input  ADLout, ADHout, mem_addr, mem_rd, cmd_ready, done
    );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module    : pc_sequencer
//  Purpose   : Control sequencer for an 8-bit CPU program counter. Executes
//              INC, JMP (absolute, two byte fetch), BRANCH (signed 8-bit
//              relative with page fix-up) and VECTOR (NMI/RESET/IRQ fetch)
//              commands, one step per sys_clock edge qualified by CLOCK_ph2.
//  Ports     : sys_clock  system clock, rising edge
//              rst        synchronous active-high reset; starts RESET vector
//              CLOCK_ph2  step strobe
//              bus        pc_sequencer_if.master (commands, memory, PC)
//  Revision  : 1.0 - initial release
// ============================================================================
module pc_sequencer (
    input  logic           sys_clock,
    input  logic           rst,
    input  logic           CLOCK_ph2,
    pc_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_LO  = 3'd1,
        RD_HI  = 3'd2,
        LOAD   = 3'd3,
        BR_ADD = 3'd4,
        BR_FIX = 3'd5,
        VEC_LO = 3'd6,
        VEC_HI = 3'd7
    } state_t;

    localparam logic [1:0] CMD_INC    = 2'b00;
    localparam logic [1:0] CMD_JMP    = 2'b01;
    localparam logic [1:0] CMD_BRANCH = 2'b10;
    localparam logic [1:0] CMD_VECTOR = 2'b11;

    localparam logic [1:0] VEC_NMI    = 2'b00;
    localparam logic [1:0] VEC_RESET  = 2'b01;
    localparam logic [1:0] VEC_IRQ    = 2'b10;

    state_t      state;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [7:0]  offset;
    logic [1:0]  vec;

    logic        accept;
    logic [7:0]  vec_base;
    logic [8:0]  sum9;
    logic        page_cross;
    logic [15:0] pc;

    assign pc     = {bus.pch_in, bus.pcl_in};
    assign accept = (state == IDLE) && bus.cmd_valid && CLOCK_ph2 && !rst;

    // Low byte of the vector address; the unused select code falls back to
    // the RESET vector.
    always_comb begin
        case (vec)
            VEC_NMI: vec_base = 8'hFA;
            VEC_IRQ: vec_base = 8'hFE;
            default: vec_base = 8'hFC;
        endcase
    end

    // The offset is sign-extended into bit 8. Bit 8 of the sum is then set
    // exactly when the result leaves the current page: as a carry for a
    // positive offset, and (because a non-crossing negative sum wraps bit 8
    // back to zero) as a borrow for a negative one. The direction of the
    // crossing is simply the sign of the offset.
    assign sum9       = {1'b0, bus.pcl_in} + {offset[7], offset};
    assign page_cross = sum9[8];

    // Output decode from the current state. Nothing here depends on
    // CLOCK_ph2 except done (and the INC accept), so outputs stay stable
    // while the step strobe is low.
    always_comb begin
        bus.INC_en    = 1'b0;
        bus.PCLin_en  = 1'b0;
        bus.PCHin_en  = 1'b0;
        bus.ADLin_en  = 1'b0;
        bus.ADHin_en  = 1'b0;
        bus.ADLout    = lo;
        bus.ADHout    = hi;
        bus.mem_addr  = pc;
        bus.mem_rd    = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.done      = 1'b0;

        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                bus.PCLin_en  = 1'b1;
                bus.PCHin_en  = 1'b1;
                if (accept && (bus.cmd == CMD_INC)) begin
                    bus.INC_en = 1'b1;
                    bus.done   = 1'b1;
                end
            end
            RD_LO: begin
                bus.mem_rd   = 1'b1;
                bus.INC_en   = 1'b1;
                bus.PCLin_en = 1'b1;
                bus.PCHin_en = 1'b1;
            end
            RD_HI: begin
                bus.mem_rd   = 1'b1;
                bus.PCLin_en = 1'b1;
                bus.PCHin_en = 1'b1;
            end
            LOAD: begin
                bus.ADLout   = lo;
                bus.ADHout   = hi;
                bus.ADLin_en = 1'b1;
                bus.ADHin_en = 1'b1;
                bus.done     = CLOCK_ph2;
            end
            BR_ADD: begin
                bus.ADLout   = sum9[7:0];
                bus.ADLin_en = 1'b1;
                bus.PCHin_en = 1'b1;
                bus.done     = CLOCK_ph2 && !page_cross;
            end
            BR_FIX: begin
                bus.ADHout   = offset[7] ? (bus.pch_in - 8'd1) : (bus.pch_in + 8'd1);
                bus.ADHin_en = 1'b1;
                bus.PCLin_en = 1'b1;
                bus.done     = CLOCK_ph2;
            end
            VEC_LO: begin
                bus.mem_addr = {8'hFF, vec_base};
                bus.mem_rd   = 1'b1;
                bus.PCLin_en = 1'b1;
                bus.PCHin_en = 1'b1;
            end
            VEC_HI: begin
                bus.mem_addr = {8'hFF, vec_base + 8'd1};
                bus.mem_rd   = 1'b1;
                bus.PCLin_en = 1'b1;
                bus.PCHin_en = 1'b1;
            end
            default: begin
                bus.PCLin_en = 1'b1;
                bus.PCHin_en = 1'b1;
            end
        endcase

        // Reset abandons whatever is in flight: no completion is reported
        // and no command can be taken on the reset edge.
        if (rst) begin
            bus.cmd_ready = 1'b0;
            bus.done      = 1'b0;
        end
    end

    // State and operand latches. Reset goes straight into the RESET vector
    // fetch so the PC is reloaded without an explicit command.
    always_ff @(posedge sys_clock) begin
        if (rst) begin
            state  <= VEC_LO;
            vec    <= VEC_RESET;
            lo     <= 8'h00;
            hi     <= 8'h00;
            offset <= 8'h00;
        end else if (CLOCK_ph2) begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        case (bus.cmd)
                            CMD_JMP: state <= RD_LO;
                            CMD_BRANCH: begin
                                offset <= bus.data_in;
                                state  <= BR_ADD;
                            end
                            CMD_VECTOR: begin
                                vec   <= bus.vec_sel;
                                state <= VEC_LO;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
                RD_LO: begin
                    lo    <= bus.data_in;
                    state <= RD_HI;
                end
                RD_HI: begin
                    hi    <= bus.data_in;
                    state <= LOAD;
                end
                LOAD:   state <= IDLE;
                BR_ADD: state <= page_cross ? BR_FIX : IDLE;
                BR_FIX: state <= IDLE;
                VEC_LO: begin
                    lo    <= bus.data_in;
                    state <= VEC_HI;
                end
                VEC_HI: begin
                    hi    <= bus.data_in;
                    state <= LOAD;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module    : tb_pc_sequencer
//  Purpose   : Self-checking bench for pc_sequencer. Models the memory and
//              the external program counter, applies a table of step
//              vectors and checks PC controls, memory requests, handshake
//              and the resulting PC after each step.
//  Revision  : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam logic [4:0] HOLD = 5'b01100;  // {INC,PCL,PCH,ADL,ADH}
    localparam logic [4:0] INCR = 5'b11100;
    localparam logic [4:0] LD   = 5'b00011;
    localparam logic [4:0] BRA  = 5'b00110;
    localparam logic [4:0] FIX  = 5'b01001;

    localparam logic [1:0] INC = 2'b00;
    localparam logic [1:0] JMP = 2'b01;
    localparam logic [1:0] BRN = 2'b10;
    localparam logic [1:0] VEC = 2'b11;

    typedef struct {
        string       name;
        logic        rst;
        logic        ph2;
        logic        valid;
        logic [1:0]  cmd;
        logic [1:0]  vs;
        logic        use_off;
        logic [7:0]  off;
        logic [4:0]  en;
        logic        rdy;
        logic        dn;
        logic        rd;
        logic [15:0] addr;
        logic [15:0] pc_after;
    } vec_t;

    logic        sys_clock = 1'b0;
    logic        rst       = 1'b1;
    logic        ph2       = 1'b0;
    logic        use_off   = 1'b0;
    logic [7:0]  off_val   = 8'h00;
    logic [15:0] pc        = 16'h0000;
    logic [7:0]  mem [0:65535];

    int total    = 0;
    int bad      = 0;
    int done_cnt = 0;

    vec_t tbl[$];
    vec_t exp_q[$];

    pc_sequencer_if bus ();

    pc_sequencer dut (
        .sys_clock (sys_clock),
        .rst       (rst),
        .CLOCK_ph2 (ph2),
        .bus       (bus)
    );

    always #5 sys_clock = ~sys_clock;

    assign bus.pcl_in  = pc[7:0];
    assign bus.pch_in  = pc[15:8];
    assign bus.data_in = use_off ? off_val : mem[bus.mem_addr];

    // External program counter: each byte takes the load value or the
    // feedback value, then the 16-bit result is optionally incremented.
    always @(posedge sys_clock) begin
        if (ph2) begin
            logic [7:0] nl;
            logic [7:0] nh;
            nl = bus.ADLin_en ? bus.ADLout : bus.pcl_in;
            nh = bus.ADHin_en ? bus.ADHout : bus.pch_in;
            pc <= {nh, nl} + {15'd0, bus.INC_en};
        end
    end

    function automatic vec_t mk(string n, logic r, logic p, logic v, logic [1:0] c,
                                logic [1:0] vs, logic uo, logic [7:0] off,
                                logic [4:0] en, logic rdy, logic dn, logic rd,
                                logic [15:0] addr, logic [15:0] pca);
        vec_t t;
        t.name = n; t.rst = r; t.ph2 = p; t.valid = v; t.cmd = c; t.vs = vs;
        t.use_off = uo; t.off = off; t.en = en; t.rdy = rdy; t.dn = dn;
        t.rd = rd; t.addr = addr; t.pc_after = pca;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Drive one cycle at the falling edge, check decoded outputs just after,
    // then check the PC once the rising edge has been taken.
    task automatic apply(input vec_t t);
        vec_t e;
        @(negedge sys_clock);
        rst           = t.rst;
        ph2           = t.ph2;
        bus.cmd_valid = t.valid;
        bus.cmd       = t.cmd;
        bus.vec_sel   = t.vs;
        use_off       = t.use_off;
        off_val       = t.off;
        exp_q.push_back(t);
        #1;
        e = exp_q.pop_front();
        if (bus.done === 1'b1) done_cnt++;
        chk({e.name, ".en"},  {11'd0, bus.INC_en, bus.PCLin_en, bus.PCHin_en,
                               bus.ADLin_en, bus.ADHin_en}, {11'd0, e.en});
        chk({e.name, ".rdy"}, {15'd0, bus.cmd_ready}, {15'd0, e.rdy});
        chk({e.name, ".done"}, {15'd0, bus.done}, {15'd0, e.dn});
        chk({e.name, ".rd"},  {15'd0, bus.mem_rd}, {15'd0, e.rd});
        if (e.rd) chk({e.name, ".addr"}, bus.mem_addr, e.addr);
        @(posedge sys_clock);
        #1;
        chk({e.name, ".pc"}, pc, e.pc_after);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        bus.cmd_valid = 1'b0;
        bus.cmd       = 2'b00;
        bus.vec_sel   = 2'b00;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
        mem[16'hFFFA] = 8'h22; mem[16'hFFFB] = 8'h11;
        mem[16'hFFFE] = 8'hCD; mem[16'hFFFF] = 8'hAB;
        mem[16'h0000] = 8'h56;
        mem[16'h8000] = 8'h34; mem[16'h8001] = 8'h12;
        mem[16'h1235] = 8'h10; mem[16'h1236] = 8'h80;
        mem[16'h8015] = 8'hF0; mem[16'h8016] = 8'h80;
        mem[16'h8110] = 8'h05; mem[16'h8111] = 8'h80;
        mem[16'h7FF5] = 8'hFF; mem[16'h7FF6] = 8'hFF;
        mem[16'h56AB] = 8'h10; mem[16'h56AC] = 8'h00;

        //           name         rst ph2 v  cmd vs uo off    en    rdy dn rd addr      pc
        tbl.push_back(mk("rst0",   1, 1, 0, INC, 0, 0, 8'h00, HOLD, 0, 0, 1, 16'hFFFC, 16'h0000));
        tbl.push_back(mk("rst1",   1, 1, 1, INC, 0, 0, 8'h00, HOLD, 0, 0, 1, 16'hFFFC, 16'h0000));
        tbl.push_back(mk("rv_lo",  0, 1, 1, INC, 0, 0, 8'h00, HOLD, 0, 0, 1, 16'hFFFC, 16'h0000));
        tbl.push_back(mk("rv_hi",  0, 1, 0, INC, 0, 0, 8'h00, HOLD, 0, 0, 1, 16'hFFFD, 16'h0000));
        tbl.push_back(mk("rv_ld",  0, 1, 0, INC, 0, 0, 8'h00, LD,   0, 1, 0, 16'h0000, 16'h8000));
        tbl.push_back(mk("idle_lo",0, 0, 1, JMP, 0, 0, 8'h00, HOLD, 1, 0, 0, 16'h0000, 16'h8000));
        tbl.push_back(mk("j1_acc", 0, 1, 1, JMP, 0, 0, 8'h00, HOLD, 1, 0, 0, 16'h0000, 16'h8000));
        tbl.push_back(mk("j1_lo",  0, 1, 1, INC, 0, 0, 8'h00, INCR, 0, 0, 1, 16'h8000, 16'h8001));
        tbl.push_back(mk("j1_hi",  0, 1, 1, INC, 0, 0, 8'h00, HOLD, 0, 0, 1, 16'h8001, 16'h8001));
        tbl.push_back(mk("j1_ld",  0, 1, 0, INC, 0, 0, 8'h00, LD,   0, 1, 0, 16'h0000, 16'h1234));
        tbl.push_back(mk("inc",    0, 1, 1, INC, 0, 0, 8'h00, INCR, 1, 1, 0, 16'h0000, 16'h1235));
        tbl.push_back(mk("j2_acc", 0, 1, 1, JMP, 0, 0, 8'h00, HOLD, 1, 0, 0, 16'h0000, 16'h1235));
        tbl.push_back(mk("j2_lo",  0, 1, 0, INC, 0, 0, 8'h00, INCR, 0, 0, 1, 16'h1235, 16'h1236));
        tbl.push_back(mk("j2_hi",  0, 1, 0, INC, 0, 0, 8'h00, HOLD, 0, 0, 1, 16'h1236, 16'h1236));
        tbl.push_back(mk("j2_ld",  0, 1, 0, INC, 0, 0, 8'h00, LD,   0, 1, 0, 16'h0000, 16'h8010));
        tbl.push_back(mk("b1_acc", 0, 1, 1, BRN, 0, 1, 8'h05, HOLD, 1, 0, 0, 16'h0000, 16'h8010));
        tbl.push_back(mk("b1_add", 0, 1, 0, INC, 0, 0, 8'h00, BRA,  0, 1, 0, 16'h0000, 16'h8015));
        tbl.push_back(mk("j3_acc", 0, 1, 1, JMP, 0, 0, 8'h00, HOLD, 1, 0, 0, 16'h0000, 16'h8015));
        tbl.push_back(mk("j3_lo",  0, 1, 0, INC, 0, 0, 8'h00, INCR, 0, 0, 1, 16'h8015, 16'h8016));
        tbl.push_back(mk("j3_hi",  0, 1, 0, INC, 0, 0, 8'h00, HOLD, 0, 0, 1, 16'h8016, 16'h8016));
        tbl.push_back(mk("j3_ld",  0, 1, 0, INC, 0, 0, 8'h00, LD,   0, 1, 0, 16'h0000, 16'h80F0));
        tbl.push_back(mk("b2_acc", 0, 1, 1, BRN, 0, 1, 8'h20, HOLD, 1, 0, 0, 16'h0000, 16'h80F0));
        tbl.push_back(mk("b2_add", 0, 1, 0, INC, 0, 0, 8'h00, BRA,  0, 0, 0, 16'h0000, 16'h8010));
        tbl.push_back(mk("b2_fix", 0, 1, 0, INC, 0, 0, 8'h00, FIX,  0, 1, 0, 16'h0000, 16'h8110));
        tbl.push_back(mk("j4_acc", 0, 1, 1, JMP, 0, 0, 8'h00, HOLD, 1, 0, 0, 16'h0000, 16'h8110));
        tbl.push_back(mk("j4_lo",  0, 1, 0, INC, 0, 0, 8'h00, INCR, 0, 0, 1, 16'h8110, 16'h8111));
        tbl.push_back(mk("j4_hi",  0, 1, 0, INC, 0, 0, 8'h00, HOLD, 0, 0, 1, 16'h8111, 16'h8111));
        tbl.push_back(mk("j4_ld",  0, 1, 0, INC, 0, 0, 8'h00, LD,   0, 1, 0, 16'h0000, 16'h8005));
        tbl.push_back(mk("b3_acc", 0, 1, 1, BRN, 0, 1, 8'hF0, HOLD, 1, 0, 0, 16'h0000, 16'h8005));
        tbl.push_back(mk("b3_add", 0, 1, 0, INC, 0, 0, 8'h00, BRA,  0, 0, 0, 16'h0000, 16'h80F5));
        tbl.push_back(mk("b3_fix", 0, 1, 0, INC, 0, 0, 8'h00, FIX,  0, 1, 0, 16'h0000, 16'h7FF5));
        tbl.push_back(mk("j5_acc", 0, 1, 1, JMP, 0, 0, 8'h00, HOLD, 1, 0, 0, 16'h0000, 16'h7FF5));
        tbl.push_back(mk("j5_lo",  0, 1, 0, INC, 0, 0, 8'h00, INCR, 0, 0, 1, 16'h7FF5, 16'h7FF6));
        tbl.push_back(mk("j5_hi",  0, 1, 0, INC, 0, 0, 8'h00, HOLD, 0, 0, 1, 16'h7FF6, 16'h7FF6));
        tbl.push_back(mk("j5_ld",  0, 1, 0, INC, 0, 0, 8'h00, LD,   0, 1, 0, 16'h0000, 16'hFFFF));
        tbl.push_back(mk("j6_acc", 0, 1, 1, JMP, 0, 0, 8'h00, HOLD, 1, 0, 0, 16'h0000, 16'hFFFF));
        tbl.push_back(mk("j6_lo",  0, 1, 0, INC, 0, 0, 8'h00, INCR, 0, 0, 1, 16'hFFFF, 16'h0000));
        tbl.push_back(mk("j6_hi",  0, 1, 0, INC, 0, 0, 8'h00, HOLD, 0, 0, 1, 16'h0000, 16'h0000));
        tbl.push_back(mk("j6_ld",  0, 1, 0, INC, 0, 0, 8'h00, LD,   0, 1, 0, 16'h0000, 16'h56AB));
        tbl.push_back(mk("j7_acc", 0, 1, 1, JMP, 0, 0, 8'h00, HOLD, 1, 0, 0, 16'h0000, 16'h56AB));
        tbl.push_back(mk("j7_lo",  0, 1, 0, INC, 0, 0, 8'h00, INCR, 0, 0, 1, 16'h56AB, 16'h56AC));
        tbl.push_back(mk("j7_hi",  0, 1, 0, INC, 0, 0, 8'h00, HOLD, 0, 0, 1, 16'h56AC, 16'h56AC));
        tbl.push_back(mk("j7_ld",  0, 1, 0, INC, 0, 0, 8'h00, LD,   0, 1, 0, 16'h0000, 16'h0010));
        tbl.push_back(mk("b4_acc", 0, 1, 1, BRN, 0, 1, 8'h80, HOLD, 1, 0, 0, 16'h0000, 16'h0010));
        tbl.push_back(mk("b4_add", 0, 1, 0, INC, 0, 0, 8'h00, BRA,  0, 0, 0, 16'h0000, 16'h0090));
        tbl.push_back(mk("b4_fix", 0, 1, 0, INC, 0, 0, 8'h00, FIX,  0, 1, 0, 16'h0000, 16'hFF90));
        tbl.push_back(mk("vn_acc", 0, 1, 1, VEC, 0, 0, 8'h00, HOLD, 1, 0, 0, 16'h0000, 16'hFF90));
        tbl.push_back(mk("vn_lo",  0, 1, 0, INC, 3, 0, 8'h00, HOLD, 0, 0, 1, 16'hFFFA, 16'hFF90));
        tbl.push_back(mk("vn_hi",  0, 1, 0, INC, 3, 0, 8'h00, HOLD, 0, 0, 1, 16'hFFFB, 16'hFF90));
        tbl.push_back(mk("vn_ld",  0, 1, 0, INC, 3, 0, 8'h00, LD,   0, 1, 0, 16'h0000, 16'h1122));
        tbl.push_back(mk("v3_acc", 0, 1, 1, VEC, 3, 0, 8'h00, HOLD, 1, 0, 0, 16'h0000, 16'h1122));
        tbl.push_back(mk("v3_lo",  0, 1, 0, INC, 0, 0, 8'h00, HOLD, 0, 0, 1, 16'hFFFC, 16'h1122));
        tbl.push_back(mk("v3_hi",  0, 1, 0, INC, 0, 0, 8'h00, HOLD, 0, 0, 1, 16'hFFFD, 16'h1122));
        tbl.push_back(mk("v3_ld",  0, 1, 0, INC, 0, 0, 8'h00, LD,   0, 1, 0, 16'h0000, 16'h8000));

        foreach (tbl[i]) apply(tbl[i]);

        // IRQ vector with the step strobe held low between steps; vec_sel is
        // changed during the gaps to show the latched select is used.
        d0 = done_cnt;
        apply(mk("irq_acc", 0, 1, 1, VEC, 2, 0, 8'h00, HOLD, 1, 0, 0, 16'h0000, 16'h8000));
        for (int k = 0; k < 3; k++)
            apply(mk("irq_lo_wait", 0, 0, 1, JMP, 0, 0, 8'h00, HOLD, 0, 0, 1, 16'hFFFE, 16'h8000));
        apply(mk("irq_lo", 0, 1, 0, INC, 0, 0, 8'h00, HOLD, 0, 0, 1, 16'hFFFE, 16'h8000));
        for (int k = 0; k < 3; k++)
            apply(mk("irq_hi_wait", 0, 0, 0, INC, 1, 0, 8'h00, HOLD, 0, 0, 1, 16'hFFFF, 16'h8000));
        apply(mk("irq_hi", 0, 1, 0, INC, 0, 0, 8'h00, HOLD, 0, 0, 1, 16'hFFFF, 16'h8000));
        for (int k = 0; k < 3; k++)
            apply(mk("irq_ld_wait", 0, 0, 0, INC, 0, 0, 8'h00, LD, 0, 0, 0, 16'h0000, 16'h8000));
        apply(mk("irq_ld", 0, 1, 0, INC, 0, 0, 8'h00, LD, 0, 1, 0, 16'h0000, 16'hABCD));
        chk("irq_done_pulses", 16'(done_cnt - d0), 16'd1);

        // Reset in the middle of a JMP: the JMP never completes and the
        // RESET vector fetch restarts on the next step.
        d0 = done_cnt;
        apply(mk("jr_acc", 0, 1, 1, JMP, 0, 0, 8'h00, HOLD, 1, 0, 0, 16'h0000, 16'hABCD));
        apply(mk("jr_lo",  0, 1, 0, INC, 0, 0, 8'h00, INCR, 0, 0, 1, 16'hABCD, 16'hABCE));
        apply(mk("jr_rst", 1, 1, 0, INC, 0, 0, 8'h00, HOLD, 0, 0, 1, 16'hABCE, 16'hABCE));
        apply(mk("jr_vlo", 0, 1, 1, INC, 0, 0, 8'h00, HOLD, 0, 0, 1, 16'hFFFC, 16'hABCE));
        apply(mk("jr_vhi", 0, 1, 1, INC, 0, 0, 8'h00, HOLD, 0, 0, 1, 16'hFFFD, 16'hABCE));
        apply(mk("jr_ld",  0, 1, 0, INC, 0, 0, 8'h00, LD,   0, 1, 0, 16'h0000, 16'h8000));
        apply(mk("jr_idle",0, 1, 0, INC, 0, 0, 8'h00, HOLD, 1, 0, 0, 16'h0000, 16'h8000));
        chk("rst_mid_done_pulses", 16'(done_cnt - d0), 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have port sys_clock  input  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port CLOCK_ph2  input  1  step strobe; the FSM advances only on sys_clock edges where CLOCK_ph2=1.
REQ-004 SHALL have ports cmd_valid  input  1  and cmd  input  2; cmd encodings: 00 INC, 01 JMP, 10 BRANCH, 11 VECTOR.
REQ-005 SHALL have port vec_sel  input  2  vector select: 00 NMI (FFFA), 01 RESET (FFFC), 10 IRQ (FFFE), 11 treated as RESET.
REQ-006 SHALL have port data_in  input  8  memory read data, valid on any step where mem_rd=1; also the signed branch offset when a BRANCH is accepted.
REQ-007 SHALL have ports pcl_in and pch_in  input  8 each  current PC value fed back from the program counter.
REQ-008 SHALL have ports INC_en, PCLin_en, PCHin_en, ADLin_en, ADHin_en  output  1 each  program counter controls.
REQ-009 SHALL have ports ADLout and ADHout  output  8 each  load value presented to the program counter.
REQ-010 SHALL have ports mem_addr  output  16  and mem_rd  output  1  for the memory read request.
REQ-011 SHALL have ports cmd_ready  output  1  and done  output  1.

Function
REQ-012 SHALL implement the states IDLE, RD_LO, RD_HI, LOAD, BR_ADD, BR_FIX, VEC_LO and VEC_HI; cmd_ready SHALL be 1 only in IDLE.
REQ-013 In IDLE with no accepted command, SHALL drive PCLin_en=PCHin_en=1 and all other enables 0 (PC hold), with mem_rd=0.
REQ-014 A command SHALL be accepted only when state=IDLE, cmd_valid=1 and CLOCK_ph2=1; cmd_valid in any other state SHALL be ignored (no queueing).
REQ-015 INC SHALL complete on the accept step: INC_en=PCLin_en=PCHin_en=1, done=1, and the state SHALL stay IDLE.
REQ-016 JMP SHALL sequence IDLE->RD_LO->RD_HI->LOAD->IDLE.
REQ-017 In RD_LO, SHALL drive mem_addr={pch_in,pcl_in} and mem_rd=1, capture data_in as lo, and increment the PC (INC_en=1, feedback enables set).
REQ-018 In RD_HI, SHALL drive the same read from the updated PC, capture data_in as hi, and hold the PC.
REQ-019 In LOAD, SHALL drive ADLout=lo, ADHout=hi and ADLin_en=ADHin_en=1 with INC_en=0 and PCLin_en=PCHin_en=0, and SHALL assert done.
REQ-020 BRANCH SHALL latch data_in as a signed offset at accept, then enter BR_ADD.
REQ-021 In BR_ADD, SHALL compute sum=pcl_in+offset (9-bit with carry/borrow) and drive ADLout=sum[7:0], ADLin_en=1 and PCHin_en=1.
REQ-022 In BR_ADD with no page crossing, SHALL assert done and return to IDLE; on a page crossing it SHALL go to BR_FIX.
REQ-023 In BR_FIX, SHALL drive ADHout=pch_in+1 (forward carry) or pch_in-1 (backward borrow), modulo 256, with ADHin_en=1 and PCLin_en=1, and SHALL assert done.
REQ-024 VECTOR SHALL latch vec_sel at accept and sequence VEC_LO->VEC_HI->LOAD.
REQ-025 In VEC_LO, SHALL drive mem_addr={FF,base}; in VEC_HI, SHALL drive mem_addr={FF,base+1}; both with mem_rd=1 and the PC held, capturing lo and hi respectively.
REQ-026 done SHALL be asserted only on the completing step and only while CLOCK_ph2=1, giving exactly one pulse per command.
REQ-027 With CLOCK_ph2=0, state and latches SHALL hold; control outputs SHALL remain decoded from the held state.
REQ-028 PC address arithmetic SHALL wrap modulo 2^16: a JMP read at PC=FFFF SHALL fetch hi from 0000.
REQ-029 Branch offset 80 SHALL mean -128; a backward branch from page 00 SHALL wrap to page FF.

Reset
REQ-030 While rst=1, the block SHALL enter VEC_LO with vec_sel forced to RESET, set lo=hi=00 and offset=00, and drive cmd_ready=0, done=0.
REQ-031 After rst deasserts, the block SHALL perform the RESET vector sequence automatically and accept commands only once LOAD completes.
REQ-032 rst asserted mid-command SHALL abandon the command on that edge, without asserting done, and restart the RESET vector sequence.

Verification
REQ-033 Reset with mem FFFC=00, FFFD=80 -> after 3 ph2 steps the PC loads 8000, done pulses once, and cmd_ready=1.
REQ-034 JMP at PC=8000, mem 8000=34, 8001=12 -> RD_LO reads 8000, RD_HI reads 8001, and LOAD sets the PC to 1234.
REQ-035 BRANCH at PC=8010 with offset 05 -> 1 step to 8015; at PC=80F0 with offset 20 -> 2 steps to 8110; at PC=8005 with offset F0 -> 2 steps to 7FF5.
REQ-036 VECTOR IRQ with CLOCK_ph2 low for 3 cycles between steps -> no state change while low, and the PC finally equals {mem FFFF, mem FFFE}.
REQ-037 cmd_valid=1 with cmd=INC during a JMP -> INC is ignored; rst pulsed in RD_HI -> no done pulse and mem_addr=FFFC on the next step.
